// File: rtl/dfxsecure_sampler_pkg.sv
// Shared types and constants for the DFx secure policy sampler.
package dfxsecure_sampler_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_EVAL,
        ST_EARLYBOOT,
        ST_RUN
    } state_e;

    // Policy value applied out of reset and whenever the fuse frame is rejected.
    localparam logic [3:0] LOCKED_POLICY_DEFAULT = 4'h0;

    // Serial frame length: policy data bits followed by one even-parity bit.
    function automatic int unsigned frame_len(input int unsigned policy_w);
        return policy_w + 1;
    endfunction

endpackage

// File: rtl/dfxsecure_fuse_deser.sv
// Fuse frame deserializer: LSB-first shift register, bit counter and parity check.
module dfxsecure_fuse_deser
    import dfxsecure_sampler_pkg::*;
#(
    parameter int unsigned POLICY_W = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                shift_en_i,
    input  logic                sdata_i,
    input  logic                abort_i,
    output logic                at_last_o,
    output logic                frame_ok_o,
    output logic                frame_err_o,
    output logic [POLICY_W-1:0] policy_o
);

    localparam int unsigned FRAME_LEN = frame_len(POLICY_W);
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN + 1);

    logic [FRAME_LEN-1:0] sreg_q, sreg_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 last_q, last_d;
    logic                 ok_q, ok_d;
    logic                 err_q, err_d;

    // Shift in the next bit and precompute completeness/parity for the FSM.
    always_comb begin
        sreg_d = sreg_q;
        cnt_d  = cnt_q;
        if (shift_en_i) begin
            sreg_d = {sdata_i, sreg_q[FRAME_LEN-1:1]};
            cnt_d  = cnt_q + CNT_W'(1);
        end
        last_d = (cnt_d == CNT_W'(FRAME_LEN - 1));
        ok_d   = (cnt_d == CNT_W'(FRAME_LEN)) && !(^sreg_d);
        // A truncated frame or bad parity is sticky until reset.
        err_d  = err_q || abort_i || ((cnt_d == CNT_W'(FRAME_LEN)) && (^sreg_d));
    end

    // Deserializer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            cnt_q  <= '0;
            last_q <= 1'b0;
            ok_q   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            sreg_q <= sreg_d;
            cnt_q  <= cnt_d;
            last_q <= last_d;
            ok_q   <= ok_d;
            err_q  <= err_d;
        end
    end

    assign at_last_o   = last_q;
    assign frame_ok_o  = ok_q;
    assign frame_err_o = err_q;
    assign policy_o    = sreg_q[POLICY_W-1:0];

endmodule

// File: rtl/dfxsecure_policy_sampler.sv
// Fuse-to-plugin policy feeder: frame capture, early-boot timer and sideband updates.
module dfxsecure_policy_sampler
    import dfxsecure_sampler_pkg::*;
#(
    parameter int unsigned          POLICY_W         = 4,
    parameter int unsigned          EARLYBOOT_CYCLES = 16,
    parameter logic [POLICY_W-1:0]  LOCKED_POLICY    = POLICY_W'(LOCKED_POLICY_DEFAULT)
) (
    input  logic                clk,
    input  logic                fdfx_powergood,
    input  logic                fuse_svalid,
    input  logic                fuse_sdata,
    input  logic                fuse_done,
    input  logic                sw_policy_req,
    input  logic [POLICY_W-1:0] sw_policy,
    output logic                sw_policy_ack,
    output logic [POLICY_W-1:0] fdfx_secure_policy,
    output logic                fdfx_policy_update,
    output logic                fdfx_earlyboot_exit,
    output logic                policy_error
);

    localparam int unsigned EB_W = (EARLYBOOT_CYCLES > 1) ? $clog2(EARLYBOOT_CYCLES) : 1;

    state_e              state_q, state_d;
    logic [POLICY_W-1:0] policy_q, policy_d;
    logic                update_q, update_d;
    logic                exit_q, exit_d;
    logic                error_q, error_d;
    logic                ack_q, ack_d;
    logic [EB_W-1:0]     eb_cnt_q, eb_cnt_d;
    logic                req_q;
    logic [POLICY_W-1:0] swpol_q;

    logic                shift_en;
    logic                abort;
    logic                at_last;
    logic                frame_ok;
    logic                frame_err;
    logic [POLICY_W-1:0] frame_policy;

    dfxsecure_fuse_deser #(
        .POLICY_W (POLICY_W)
    ) u_deser (
        .clk         (clk),
        .rst_n       (fdfx_powergood),
        .shift_en_i  (shift_en),
        .sdata_i     (fuse_sdata),
        .abort_i     (abort),
        .at_last_o   (at_last),
        .frame_ok_o  (frame_ok),
        .frame_err_o (frame_err),
        .policy_o    (frame_policy)
    );

    // Next-state and output decode for the sampler FSM.
    always_comb begin
        state_d  = state_q;
        policy_d = policy_q;
        update_d = 1'b0;
        exit_d   = exit_q;
        error_d  = error_q;
        ack_d    = 1'b0;
        eb_cnt_d = eb_cnt_q;
        shift_en = 1'b0;
        abort    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                shift_en = fuse_svalid;
                // A same-cycle bit is captured, but one bit can never complete a frame.
                if (fuse_done) begin
                    abort   = 1'b1;
                    state_d = ST_EVAL;
                end else if (fuse_svalid) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en = fuse_svalid;
                // The bit is counted before fuse_done is judged.
                if (fuse_svalid && at_last) begin
                    state_d = ST_EVAL;
                end else if (fuse_done) begin
                    abort   = 1'b1;
                    state_d = ST_EVAL;
                end
            end
            ST_EVAL: begin
                update_d = 1'b1;
                eb_cnt_d = EB_W'(EARLYBOOT_CYCLES - 1);
                state_d  = ST_EARLYBOOT;
                if (frame_ok && !frame_err) begin
                    policy_d = frame_policy;
                end else begin
                    policy_d = LOCKED_POLICY;
                    error_d  = 1'b1;
                end
            end
            ST_EARLYBOOT: begin
                if (eb_cnt_q == '0) begin
                    exit_d  = 1'b1;
                    state_d = ST_RUN;
                end else begin
                    eb_cnt_d = eb_cnt_q - EB_W'(1);
                end
            end
            ST_RUN: begin
                // A pending request is acked at most every other cycle.
                if (req_q && !ack_q) begin
                    ack_d = 1'b1;
                    if (!error_q) begin
                        policy_d = swpol_q;
                        update_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Sampler state and output registers.
    always_ff @(posedge clk or negedge fdfx_powergood) begin
        if (!fdfx_powergood) begin
            state_q  <= ST_IDLE;
            policy_q <= LOCKED_POLICY;
            update_q <= 1'b0;
            exit_q   <= 1'b0;
            error_q  <= 1'b0;
            ack_q    <= 1'b0;
            eb_cnt_q <= '0;
            req_q    <= 1'b0;
            swpol_q  <= LOCKED_POLICY;
        end else begin
            state_q  <= state_d;
            policy_q <= policy_d;
            update_q <= update_d;
            exit_q   <= exit_d;
            error_q  <= error_d;
            ack_q    <= ack_d;
            eb_cnt_q <= eb_cnt_d;
            req_q    <= sw_policy_req;
            swpol_q  <= sw_policy;
        end
    end

    assign sw_policy_ack       = ack_q;
    assign fdfx_secure_policy  = policy_q;
    assign fdfx_policy_update  = update_q;
    assign fdfx_earlyboot_exit = exit_q;
    assign policy_error        = error_q;

endmodule

// File: tb/tb_dfxsecure_policy_sampler.sv
// Self-checking bench: event-level reference model of frame outcome and sideband acks.
module tb_dfxsecure_policy_sampler;

    localparam int unsigned PW     = 4;
    localparam int unsigned EB     = 16;
    localparam int unsigned LEN    = PW + 1;
    localparam logic [3:0]  LOCKED = 4'h0;
    localparam int          BIG    = 1 << 30;

    logic          clk = 1'b0;
    logic          fdfx_powergood;
    logic          fuse_svalid;
    logic          fuse_sdata;
    logic          fuse_done;
    logic          sw_policy_req;
    logic [PW-1:0] sw_policy;
    logic          sw_policy_ack;
    logic [PW-1:0] fdfx_secure_policy;
    logic          fdfx_policy_update;
    logic          fdfx_earlyboot_exit;
    logic          policy_error;

    dfxsecure_policy_sampler #(
        .POLICY_W         (PW),
        .EARLYBOOT_CYCLES (EB),
        .LOCKED_POLICY    (LOCKED)
    ) dut (
        .clk                 (clk),
        .fdfx_powergood      (fdfx_powergood),
        .fuse_svalid         (fuse_svalid),
        .fuse_sdata          (fuse_sdata),
        .fuse_done           (fuse_done),
        .sw_policy_req       (sw_policy_req),
        .sw_policy           (sw_policy),
        .sw_policy_ack       (sw_policy_ack),
        .fdfx_secure_policy  (fdfx_secure_policy),
        .fdfx_policy_update  (fdfx_policy_update),
        .fdfx_earlyboot_exit (fdfx_earlyboot_exit),
        .policy_error        (policy_error)
    );

    always #5 clk = ~clk;

    // Reference model: expected events keyed by edge number since reset release.
    int         cyc;
    int         n_tests;
    int         n_fail;
    int         exit_edge;
    int         err_edge;
    logic [3:0] exp_pol;
    logic [3:0] pol_change[int];
    bit         exp_upd[int];
    bit         exp_ack[int];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic check_cycle();
        if (pol_change.exists(cyc)) exp_pol = pol_change[cyc];
        chk("policy", 32'(fdfx_secure_policy), 32'(exp_pol));
        chk("update", 32'(fdfx_policy_update), 32'(exp_upd.exists(cyc)));
        chk("ack",    32'(sw_policy_ack),      32'(exp_ack.exists(cyc)));
        chk("exit",   32'(fdfx_earlyboot_exit), 32'(cyc >= exit_edge));
        chk("error",  32'(policy_error),       32'(cyc >= err_edge));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset: outputs must be at reset values before any clock edge.
    task automatic do_reset();
        fdfx_powergood = 1'b0;
        fuse_svalid    = 1'b0;
        fuse_sdata     = 1'b0;
        fuse_done      = 1'b0;
        sw_policy_req  = 1'b0;
        sw_policy      = 4'(($urandom));
        #1;
        chk("rst_policy", 32'(fdfx_secure_policy), 32'(LOCKED));
        chk("rst_update", 32'(fdfx_policy_update), 32'd0);
        chk("rst_ack",    32'(sw_policy_ack), 32'd0);
        chk("rst_exit",   32'(fdfx_earlyboot_exit), 32'd0);
        chk("rst_error",  32'(policy_error), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        fdfx_powergood = 1'b1;
        pol_change.delete();
        exp_upd.delete();
        exp_ack.delete();
        exp_pol   = LOCKED;
        exit_edge = BIG;
        err_edge  = BIG;
        cyc       = 0;
    endtask

    // Send nsend bits of the frame, then close it; the model predicts from the edge T
    // where the frame completes or fuse_done is seen.
    task automatic run_frame(input logic [3:0] data, input bit flip, input int nsend,
                             input bit gapped, input bit done_with_last, input bit extra);
        logic [4:0] fr;
        int         t_edge;
        bit         good;
        fr = {(^data) ^ flip, data};
        for (int i = 0; i < nsend; i++) begin
            if (gapped) begin
                fuse_svalid = 1'b0;
                fuse_sdata  = 1'($urandom);
                step();
            end
            fuse_svalid = 1'b1;
            fuse_sdata  = fr[i];
            if (i == nsend - 1 && done_with_last) fuse_done = 1'b1;
            step();
        end
        if (nsend == LEN || (nsend > 0 && done_with_last)) begin
            t_edge = cyc;
        end else begin
            fuse_svalid = 1'b0;
            fuse_done   = 1'b1;
            step();
            t_edge = cyc;
        end
        good = (nsend == LEN) && !flip;
        pol_change[t_edge + 1] = good ? data : LOCKED;
        exp_upd[t_edge + 1]    = 1'b1;
        if (!good) err_edge = t_edge + 1;
        exit_edge = t_edge + 1 + EB;
        fuse_done = 1'b1;
        if (extra) begin
            for (int j = 0; j < 6; j++) begin
                fuse_svalid = 1'($urandom);
                fuse_sdata  = 1'($urandom);
                step();
            end
        end
        fuse_svalid = 1'b0;
    endtask

    // Raise a request and hold it for nacks acknowledgements, then drop it.
    task automatic sw_request(input logic [3:0] p, input int nacks);
        int r;
        int first;
        int a;
        int got;
        sw_policy_req = 1'b1;
        sw_policy     = p;
        r     = cyc + 1;
        first = ((r > exit_edge) ? r : exit_edge) + 1;
        for (int j = 0; j < nacks; j++) begin
            a = first + 2 * j;
            exp_ack[a] = 1'b1;
            if (err_edge > a) begin
                exp_upd[a]    = 1'b1;
                pol_change[a] = p;
            end
        end
        got = 0;
        for (int k = 0; k < int'(EB) + 64 && got < nacks; k++) begin
            step();
            if (sw_policy_ack === 1'b1) got++;
        end
        chk("ack_count", 32'(got), 32'(nacks));
        sw_policy_req = 1'b0;
        sw_policy     = 4'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;

        // Good frame 5, request held through early boot, then more requests.
        do_reset();
        run_frame(4'h5, 1'b0, LEN, 1'b0, 1'b0, 1'b0);
        idle(2);
        sw_request(4'hA, 1);
        idle(2);
        sw_request(4'($urandom), 1);
        sw_request(4'($urandom), 3);
        idle(3);

        // Bad parity: locked policy, sideband acked without update.
        do_reset();
        run_frame(4'h5, 1'b1, LEN, 1'b0, 1'b0, 1'b0);
        idle(EB + 2);
        sw_request(4'h2, 1);
        idle(3);

        // Short frame closed by fuse_done.
        do_reset();
        run_frame(4'h5, 1'b0, 2, 1'b0, 1'b0, 1'b0);
        idle(EB + 3);

        // Gapped valid with trailing bits after the frame.
        do_reset();
        run_frame(4'h3, 1'b0, LEN, 1'b1, 1'b0, 1'b1);
        idle(EB);
        sw_request(4'($urandom), 1);
        idle(2);

        // Reset in the middle of a frame, then a clean frame 7.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            fuse_svalid = 1'b1;
            fuse_sdata  = 1'b1;
            step();
        end
        do_reset();
        run_frame(4'h7, 1'b0, LEN, 1'b0, 1'b0, 1'b0);
        idle(EB + 2);

        // Randomized frames, truncations, done timing and requests.
        for (int it = 0; it < 10; it++) begin
            logic [3:0] d;
            bit         fl;
            int         ns;
            do_reset();
            d  = 4'($urandom);
            fl = ($urandom_range(0, 3) == 0);
            ns = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, LEN - 1)) : int'(LEN);
            idle(int'($urandom_range(0, 2)));
            run_frame(d, fl, ns, 1'($urandom), 1'($urandom), 1'($urandom));
            idle(int'($urandom_range(0, EB + 4)));
            sw_request(4'($urandom), 1);
            idle(int'($urandom_range(0, 3)));
            sw_request(4'($urandom), int'($urandom_range(1, 3)));
            idle(2);
        end

        do_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
